// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand/result handshake and full-adder bit lanes of the serial adder
interface serial_add_ctrl_if #(parameter int WIDTH = 4);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             bit_a;
    logic             bit_b;
    logic             bit_cin;
    logic             bit_s;
    logic             bit_c;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             overflow;
    modport master (
        output start, sub, in_a, in_b, bit_s, bit_c,
        input  bit_a, bit_b, bit_cin, busy, done, sum_out, carry_out, overflow
    );
    modport slave (
        input  start, sub, in_a, in_b, bit_s, bit_c,
        output bit_a, bit_b, bit_cin, busy, done, sum_out, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: drives an external one-bit full adder LSB first to add/subtract WIDTH-bit operands
module serial_add_ctrl #(parameter int WIDTH = 4) (
    input logic             clk,
    input logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry_q, busy_q, done_q, carry_out_q, overflow_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            r_sh        <= '0;
            cnt         <= '0;
            carry_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (state != SHIFT) begin
            // IDLE and DONE accept identically, giving back-to-back operation
            state  <= bus.start ? SHIFT : IDLE;
            busy_q <= bus.start;
            done_q <= 1'b0;
            if (bus.start) begin
                a_sh    <= bus.in_a;
                b_sh    <= bus.sub ? ~bus.in_b : bus.in_b;
                carry_q <= bus.sub;
                cnt     <= '0;
                r_sh    <= '0;
            end
        end else begin
            r_sh    <= {bus.bit_s, r_sh[WIDTH-1:1]};
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry_q <= bus.bit_c;
            cnt     <= cnt + 1'b1;
            busy_q  <= cnt != LAST;
            done_q  <= cnt == LAST;
            if (cnt == LAST) begin
                state       <= DONE;
                sum_q       <= {bus.bit_s, r_sh[WIDTH-1:1]};
                carry_out_q <= bus.bit_c;
                overflow_q  <= carry_q ^ bus.bit_c;
            end
        end
    end
    assign bus.bit_a     = busy_q & a_sh[0];
    assign bus.bit_b     = busy_q & b_sh[0];
    assign bus.bit_cin   = busy_q & carry_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum_out   = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboarded random/directed bench with a behavioural full-adder cell
module tb_serial_add_ctrl;
    localparam int W = 4;
    localparam int MOD = 1 << W;
    localparam int HALF = 1 << (W - 1);
    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } res_t;
    logic clk, rst;
    int passed = 0, total = 0, done_cnt = 0, busy_run = 0;
    res_t exp_q[$];
    serial_add_ctrl_if #(.WIDTH(W)) bus();
    serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.bit_s = bus.bit_a ^ bus.bit_b ^ bus.bit_cin;
    assign bus.bit_c = (bus.bit_a & bus.bit_b) | (bus.bit_cin & (bus.bit_a ^ bus.bit_b));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    function automatic res_t model(input int a, input int b, input bit s);
        int sa, sb, r;
        res_t e;
        sa = a >= HALF ? a - MOD : a;
        sb = b >= HALF ? b - MOD : b;
        r = s ? sa - sb : sa + sb;
        e.s = W'(s ? (a - b + MOD) % MOD : (a + b) % MOD);
        e.co = s ? (a >= b) : (a + b >= MOD);
        e.ov = (r >= HALF) || (r < -HALF);
        return e;
    endfunction
    always @(negedge clk) begin
        if (!bus.busy) chk("bits_idle", {bus.bit_a, bus.bit_b, bus.bit_cin}, 0);
        if (bus.busy) busy_run++;
        else begin
            if (bus.done) begin
                res_t e;
                done_cnt++;
                chk("busy_len", busy_run, W);
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sum_out", bus.sum_out, e.s);
                    chk("carry_out", bus.carry_out, e.co);
                    chk("overflow", bus.overflow, e.ov);
                end
            end
            busy_run = 0;
        end
    end
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask
    // called at a negedge; if that is the DONE cycle the start is back-to-back
    task automatic run(input int a, input int b, input bit s, input bit hold);
        int n;
        bus.start = 1;
        bus.in_a = W'(a);
        bus.in_b = W'(b);
        bus.sub = s;
        exp_q.push_back(model(a, b, s));
        @(negedge clk);
        chk("busy_after_start", bus.busy, 1);
        if (hold) begin
            bus.in_a = ~W'(a);
            bus.in_b = W'(a + 1);
            bus.sub = ~s;
            repeat (2) @(negedge clk);
            bus.start = 0;
            wait_done(n);
            chk("latency", n + 3, W + 1);
        end else begin
            bus.start = 0;
            wait_done(n);
            chk("latency", n + 1, W + 1);
        end
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int d;
        rst = 0;
        bus.start = 0;
        bus.sub = 0;
        bus.in_a = '0;
        bus.in_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum", bus.sum_out, 0);
        chk("rst_flags", {bus.carry_out, bus.overflow}, 0);
        rst = 1;
        @(negedge clk);
        run(3, 5, 0, 0);
        @(negedge clk);
        run(15, 1, 0, 0);
        @(negedge clk);
        run(5, 3, 1, 0);
        @(negedge clk);
        run(3, 5, 1, 0);
        @(negedge clk);
        run(6, 7, 0, 1);
        run(1, 1, 0, 0);
        @(negedge clk);
        bus.start = 1;
        bus.in_a = 4'd9;
        bus.in_b = 4'd9;
        bus.sub = 0;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_sum", bus.sum_out, 0);
        chk("abort_flags", {bus.carry_out, bus.overflow}, 0);
        d = done_cnt;
        repeat (8) @(negedge clk);
        chk("abort_no_done", done_cnt, d);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(1) == 0) repeat ($urandom_range(2)) @(negedge clk);
            run($urandom_range(MOD - 1), $urandom_range(MOD - 1), 1'($urandom_range(1)), 0);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencing controller for a single shared one-bit full adder, turning it into a WIDTH-bit bit-serial adder/subtractor. The controller accepts two operands on a start pulse and presents them to the external full adder LSB first, one bit per clock. It holds the carry in a flip-flop between bits, collects the sum bits into a result register, and reports completion with a done pulse. It sits between the operand source and the gate-level full-adder cell and owns all registers; the adder cell stays purely combinational.

## Interface
- WIDTH, 4, operand/result width in bits; ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = A+B, 1 = A−B; sampled with start.
- in_a  in  WIDTH  operand A; sampled with start.
- in_b  in  WIDTH  operand B; sampled with start.
- bit_a  out  1  current A bit to full adder.
- bit_b  out  1  current (possibly inverted) B bit to full adder.
- bit_cin  out  1  carry flip-flop value to full adder.
- bit_s  in  1  sum from full adder (combinational return).
- bit_c  in  1  carry from full adder (combinational return).
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse in DONE.
- sum_out  out  WIDTH  result; stable from done until the next accepted start.
- carry_out  out  1  final carry (for sub: 1 = no borrow).
- overflow  out  1  two's-complement overflow of the operation.

## Operation
- Registers: a_sh, b_sh, r_sh (WIDTH each), carry_q, cnt (ceil(log2 WIDTH) bits), state.
- Reset (rst=0 at a clk edge): state=IDLE. All registers, sum_out, carry_out and overflow become 0. busy=0, done=0, bit_* =0. Reset wins over every other event, including mid-SHIFT; the operation in progress is dropped.
- IDLE: on start=1, a_sh←in_a, b_sh←(sub ? ~in_b : in_b), carry_q←sub, cnt←0, r_sh←0, state→SHIFT. Otherwise hold.
- SHIFT, each cycle:
  - r_sh←{bit_s, r_sh[WIDTH-1:1]}
  - a_sh, b_sh shift right by 1 (zero fill)
  - carry_q←bit_c
  - cnt←cnt+1
  - start is ignored.
- SHIFT exit: when cnt==WIDTH-1, the same edge also does:
  - sum_out←{bit_s, r_sh[WIDTH-1:1]}
  - carry_out←bit_c
  - overflow←carry_q ^ bit_c (carry into MSB xor carry out of MSB)
  - state→DONE
- DONE: done=1 for exactly this cycle. With start=1, it behaves like IDLE-accept (state→SHIFT, back-to-back). Otherwise state→IDLE.
- bit_a=a_sh[0], bit_b=b_sh[0], bit_cin=carry_q in SHIFT only; all 0 in IDLE and DONE.
- sum_out, carry_out and overflow change only at the SHIFT-exit edge and on reset.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.

## Timing
- Start accepted at edge 0; SHIFT occupies cycles 1..WIDTH (busy=1); results and done valid in cycle WIDTH+1.
- Latency start→done: WIDTH+1 cycles.
- Throughput with back-to-back start in DONE: one operation per WIDTH+1 cycles.
- Combinational path bit_a/bit_b/bit_cin → adder → bit_s/bit_c is captured in the same cycle; no registers on the return path.
- Reset asserted in any cycle: outputs read 0 from the following cycle; no done is issued for the aborted operation.

## Test plan
- WIDTH=4, A=3, B=5, sub=0 → cycle 5: sum_out=8, carry_out=0, overflow=1, done=1 for one cycle; busy=1 exactly in cycles 1–4.
- A=15, B=1, sub=0 → sum_out=0, carry_out=1, overflow=0.
- A=5, B=3, sub=1 → sum_out=2, carry_out=1, overflow=0. A=3, B=5, sub=1 → sum_out=14, carry_out=0, overflow=0.
- Start held high during SHIFT with different operands → ignored; result is for the first operands. Start=1 in DONE with A=1, B=1 → busy next cycle; second done 5 cycles later with sum_out=2.
- rst=0 in cycle 2 of an operation → cycle 3: state IDLE, busy=0, sum_out=0, carry_out=0, overflow=0; no done pulse follows.
- Random A, B, sub over 500 operations vs. a (A±B) mod 16 reference, including checks of carry_out and overflow; bit_* must be 0 whenever busy=0.
